// File: rtl/sbqm_pkg.sv
// Shared definitions for the smart bank queue manager blocks.
package sbqm_pkg;

  // Default width of the people count; capacity is 2^N-1.
  localparam int unsigned N_DEF   = 3;
  // Teller count width, fixed by the wait-time table layout.
  localparam int unsigned T_W_DEF = 2;
  // Queue capacity and lookup address width at the default sizing.
  localparam int unsigned P_MAX   = (1 << N_DEF) - 1;
  localparam int unsigned ADR_W   = N_DEF + T_W_DEF;

  // What the occupancy register does on a given cycle.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_DEC,
    ACT_LOAD1
  } cnt_act_e;

  // Largest count representable in n bits.
  function automatic int unsigned p_max(input int unsigned n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/queue_ctrl_photo_edge.sv
// Photocell conditioning: two-flop synchroniser plus a previous-value flop.
// Emits a one-cycle pulse when the beam clears (line falls), i.e. once the
// person has fully passed, regardless of how long the beam was blocked.
module photo_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronise the asynchronous line and keep its previous synchronised value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Beam-clear event: was blocked last cycle, clear now.
  always_comb begin
    pulse = s3 & ~s2;
  end

endmodule

// File: rtl/queue_ctrl.sv
// Queue occupancy controller: counts people between the back (entry) and
// front (exit) photocells, registers the active teller count and drives the
// {people, tellers} wait-time lookup address plus status/error flags.
module queue_ctrl
  import sbqm_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned T_W = T_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Bphoto,
  input  logic             Fphoto,
  input  logic [T_W-1:0]   Tcount,
  output logic [N-1:0]     Pcount,
  output logic [N+T_W-1:0] Adress,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [N-1:0] P_LIM = N'(p_max(N));

  logic           b_evt;
  logic           f_evt;
  logic [T_W-1:0] tcount_q;
  cnt_act_e       act;
  logic           ovf_d;
  logic           udf_d;
  logic [N-1:0]   pcount_d;

  photo_edge u_back (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (Bphoto),
    .pulse (b_evt)
  );

  photo_edge u_front (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (Fphoto),
    .pulse (f_evt)
  );

  // Status flags and lookup address straight from registered state.
  always_comb begin
    full   = (Pcount == P_LIM);
    empty  = (Pcount == '0);
    Adress = {Pcount, tcount_q};
  end

  // Decide the count action and any rejected-event error for this cycle.
  // A simultaneous entry/exit on an empty queue accepts the entry and
  // flags the exit; on a non-empty queue it is a net no-op, even when full.
  always_comb begin
    act   = ACT_HOLD;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    unique case ({b_evt, f_evt})
      2'b10: begin
        if (full) ovf_d = 1'b1;
        else      act   = ACT_INC;
      end
      2'b01: begin
        if (empty) udf_d = 1'b1;
        else       act   = ACT_DEC;
      end
      2'b11: begin
        if (empty) begin
          act   = ACT_LOAD1;
          udf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next occupancy value for the chosen action.
  always_comb begin
    pcount_d = Pcount;
    unique case (act)
      ACT_INC:   pcount_d = Pcount + 1'b1;
      ACT_DEC:   pcount_d = Pcount - 1'b1;
      ACT_LOAD1: pcount_d = N'(1);
      default:   pcount_d = Pcount;
    endcase
  end

  // Occupancy, teller count and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pcount   <= '0;
      tcount_q <= '0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      Pcount   <= pcount_d;
      tcount_q <= Tcount;
      err_ovf  <= ovf_d;
      err_udf  <= udf_d;
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl: directed photocell stimulus, a sample-history model
// checked every cycle, and literal expectations at key points.
module tb_queue_ctrl;

  localparam int N     = 3;
  localparam int P_MAX = (1 << N) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Bphoto;
  logic       Fphoto;
  logic [1:0] Tcount;
  logic [2:0] Pcount;
  logic [4:0] Adress;
  logic       full;
  logic       empty;
  logic       err_ovf;
  logic       err_udf;

  always #5 clk = ~clk;

  queue_ctrl #(.N(3), .T_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Bphoto  (Bphoto),
    .Fphoto  (Fphoto),
    .Tcount  (Tcount),
    .Pcount  (Pcount),
    .Adress  (Adress),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a line fall between clock samples j-1 and j is a person passing;
  // it takes effect on sample j+2. Count saturates at 0 and P_MAX.
  int         m_cnt;
  logic [1:0] m_t;
  logic       m_ovf;
  logic       m_udf;
  logic [3:0] hb;
  logic [3:0] hf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_t = 0; m_ovf = 0; m_udf = 0; hb = 0; hf = 0;
    end else begin
      logic in_e, out_e;
      hb = {hb[2:0], Bphoto};
      hf = {hf[2:0], Fphoto};
      in_e  = hb[3] & ~hb[2];
      out_e = hf[3] & ~hf[2];
      m_ovf = 0;
      m_udf = 0;
      if (in_e && !out_e) begin
        if (m_cnt < P_MAX) m_cnt = m_cnt + 1; else m_ovf = 1;
      end else if (!in_e && out_e) begin
        if (m_cnt > 0) m_cnt = m_cnt - 1; else m_udf = 1;
      end else if (in_e && out_e) begin
        if (m_cnt == 0) begin m_cnt = 1; m_udf = 1; end
      end
      m_t = Tcount;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("Pcount",  Pcount,  m_cnt);
    check("Adress",  Adress,  m_cnt * 4 + m_t);
    check("full",    full,    m_cnt == P_MAX);
    check("empty",   empty,   m_cnt == 0);
    check("err_ovf", err_ovf, m_ovf);
    check("err_udf", err_udf, m_udf);
  end

  int ovf_seen;
  int udf_seen;

  // Count error pulse cycles for windowed literal checks.
  always @(negedge clk) begin
    if (err_ovf === 1'b1) ovf_seen++;
    if (err_udf === 1'b1) udf_seen++;
  end

  // Advance n rising edges and land 3 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic pulse(input logic b, input logic f, input int hi);
    Bphoto = b;
    Fphoto = f;
    tick(hi);
    Bphoto = 1'b0;
    Fphoto = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_Pcount"},  Pcount,  0);
    check({tag, "_Adress"},  Adress,  0);
    check({tag, "_empty"},   empty,   1);
    check({tag, "_full"},    full,    0);
    check({tag, "_err_ovf"}, err_ovf, 0);
    check({tag, "_err_udf"}, err_udf, 0);
  endtask

  initial begin
    Bphoto = 1'b0;
    Fphoto = 1'b0;
    Tcount = 2'd2;
    rst_n  = 1'b0;
    ovf_seen = 0;
    udf_seen = 0;
    #12;
    check_reset_values("rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick(2);

    // First entry: increment lands on the third edge after the fall.
    Bphoto = 1'b1;
    tick(4);
    Bphoto = 1'b0;
    tick(1);
    check("lat_edge_k",   Pcount, 0);
    tick(1);
    check("lat_edge_k1",  Pcount, 0);
    tick(1);
    check("lat_edge_k2",  Pcount, 1);
    tick(2);
    pulse(1, 0, 4);
    pulse(1, 0, 4);
    check("three_in_P",   Pcount, 3);
    check("three_in_adr", Adress, 5'b01110);
    check("three_in_emp", empty,  0);

    // Fill, then overflow attempt.
    repeat (4) pulse(1, 0, 4);
    check("fill_P",    Pcount, 7);
    check("fill_full", full,   1);
    ovf_seen = 0;
    pulse(1, 0, 4);
    check("ovf_pulses", ovf_seen, 1);
    check("ovf_hold",   Pcount,   7);
    pulse(0, 1, 4);
    check("exit_P",    Pcount, 6);
    check("exit_full", full,   0);

    // Drain, then underflow and simultaneous-on-empty.
    repeat (6) pulse(0, 1, 4);
    udf_seen = 0;
    pulse(0, 1, 4);
    check("udf_pulses", udf_seen, 1);
    check("udf_hold",   Pcount,   0);
    udf_seen = 0;
    ovf_seen = 0;
    pulse(1, 1, 4);
    check("both_empty_P",   Pcount,   1);
    check("both_empty_udf", udf_seen, 1);
    check("both_empty_ovf", ovf_seen, 0);

    // Simultaneous when full and mid-range.
    repeat (6) pulse(1, 0, 4);
    udf_seen = 0;
    ovf_seen = 0;
    pulse(1, 1, 4);
    check("both_full_P",   Pcount,   7);
    check("both_full_ovf", ovf_seen, 0);
    check("both_full_udf", udf_seen, 0);
    repeat (3) pulse(0, 1, 4);
    pulse(1, 1, 4);
    check("both_mid_P", Pcount, 4);

    // Teller count passes through, including zero.
    Tcount = 2'd0;
    tick(2);
    check("tc0_adr", Adress, 5'b10000);
    Tcount = 2'd3;
    tick(2);
    check("tc3_adr", Adress, 5'b10011);

    // Long block counts once, only after release.
    Bphoto = 1'b1;
    tick(50);
    check("long_held", Pcount, 4);
    Bphoto = 1'b0;
    tick(4);
    check("long_release", Pcount, 5);

    // One-cycle glitch straddling a rising edge.
    #2;
    Bphoto = 1'b1;
    #10;
    Bphoto = 1'b0;
    @(posedge clk);
    #3;
    tick(4);
    check("glitch_le_one", (Pcount == 3'd5) || (Pcount == 3'd6), 1);
    if (Pcount == 3'd6) pulse(0, 1, 4);
    check("pre_rst_P", Pcount, 5);

    // Asynchronous reset mid-cycle with the front beam blocked.
    Fphoto = 1'b1;
    tick(2);
    #4;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #3;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    udf_seen = 0;
    Fphoto = 1'b0;
    tick(4);
    check("post_rst_udf", udf_seen, 1);
    check("post_rst_P",   Pcount,   0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
Queue occupancy controller for the smart bank queue manager. It consumes the back (entry) and front (exit to teller) photocell lines and keeps the count of people waiting. It registers the active-teller count and drives the {people, tellers} address into the wait-time lookup, along with full, empty and error flags for the display and alarm logic.

Parameters:
N, 3, width of the people count; queue capacity is 2^N-1 (7 at default)
T_W, 2, width of the teller count (fixed at 2 for the wait-time table; not for override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low; clears all state
Bphoto  input  1  back photocell, high while beam blocked (person entering), asynchronous to clk
Fphoto  input  1  front photocell, high while beam blocked (person leaving to a teller), asynchronous to clk
Tcount  input  T_W  number of tellers currently serving (0..3), quasi-static
Pcount  output  N  people currently in queue
Adress  output  N+2  wait-time lookup address = {Pcount, Tcount_q}
full  output  1  Pcount == 2^N-1
empty  output  1  Pcount == 0
err_ovf  output  1  one-cycle pulse: entry seen while full and not simultaneous with a valid exit
err_udf  output  1  one-cycle pulse: exit seen while empty

Behaviour:
- Reset (rst_n low, async): Pcount=0, Tcount_q=0, Adress=0, empty=1, full=0, err_ovf=0, err_udf=0, all synchroniser/edge flops=0.
- Each photocell line: 2-flop synchroniser (s1, s2) then a previous-value flop s3. Event = s3 & ~s2, i.e. the beam clears (person has passed).
- Latency: the line falls before edge k. s2 goes low at edge k+1. The event is high during cycle k+1..k+2. Pcount updates at edge k+2. One event per falling edge regardless of pulse length; a high time of at least 2 clk cycles is required to be seen.
- Count update, per cycle with in = B event, out = F event:
  - in & ~out: if !full, Pcount+1; else hold, err_ovf=1.
  - ~in & out: if !empty, Pcount-1; else hold, err_udf=1.
  - in & out: if empty, Pcount=1 and err_udf=1 (exit invalid, entry accepted); otherwise hold (includes full, no err_ovf).
  - neither: hold.
- Pcount never wraps. Saturates at 0 and 2^N-1.
- Tcount_q <= Tcount every cycle (1-cycle latency). Tcount=0 is passed through unchanged; the table returns 0 wait.
- Adress, full and empty are combinational from registered Pcount/Tcount_q, so they are glitch-free relative to register outputs and valid in the same cycle as Pcount.
- err_ovf/err_udf are registered and high for exactly one cycle per rejected event.
- Reset mid-operation: all state cleared immediately. A sensor still blocked at reset release produces one event when it later clears (sync flops reset to 0). This is required behaviour.

Decomposition:
- Shared package sbqm_pkg: default N=3, T_W=2, localparam P_MAX=2^N-1, address width N+T_W.
- Sub-module photo_edge (synchroniser + falling-edge detect, clk/rst_n, in -> pulse), instantiated for Bphoto and Fphoto.
- The wait-time lookup stays outside; queue_ctrl only drives Adress.

Test Plan:
- Reset, then 3 Bphoto pulses (4 cycles high each), Tcount=2 -> Pcount=3, Adress=5'b01110, empty=0. Each increment lands on the 3rd edge after the fall.
- From Pcount=7: one Bphoto pulse -> Pcount stays 7, full=1, err_ovf single-cycle pulse. Then one Fphoto pulse -> Pcount=6, full=0.
- From Pcount=0: one Fphoto pulse -> Pcount=0, err_udf one pulse. Then Bphoto and Fphoto fall on the same cycle -> Pcount=1, err_udf pulse, err_ovf=0.
- From Pcount=7: Bphoto and Fphoto fall on the same cycle -> Pcount=7, no error pulses. From Pcount=4: same stimulus -> Pcount=4.
- Bphoto held high 50 cycles -> exactly one increment after release. A 1-cycle glitch aligned mid-cycle -> no change or at most one count, never two.
- Pcount=5, assert rst_n low asynchronously mid-cycle while Fphoto is high -> outputs at reset values immediately. After release, Fphoto fall -> err_udf pulse, Pcount=0.
